// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared widths, FSM state and FIFO entry type for alu_issue_ctrl
package alu_issue_pkg;
   localparam int OPND_W = 6;
   localparam int OP_W = 2;
   localparam int RES_W = 8;
   typedef enum logic {ST_IDLE, ST_SETTLE} state_t;
   typedef struct packed {
      logic [RES_W-1:0] result;
      logic [OP_W-1:0] op;
   } entry_t;
endpackage

// File: rtl/alu_issue_ctrl_fifo.sv
// alu_result_fifo: DEPTH-entry result/opcode FIFO
// Ports: clk, rst_n (sync active-low), push/push_data, pop, empty, count, head (zero when empty).
module alu_result_fifo
   import alu_issue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  entry_t                   push_data,
   input  logic                     pop,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output entry_t                   head
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   entry_t mem_q [DEPTH];
   entry_t mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] cnt_q, cnt_d;
   logic do_push, do_pop;
   always_comb begin
      do_pop = pop & (cnt_q != '0);
      // a push into a full FIFO is only taken when a pop frees the slot on the same edge
      do_push = push & ((cnt_q != FULL_CNT) | do_pop);
      mem_d = mem_q;
      if (do_push) mem_d[wr_q] = push_data;
      wr_d = do_push ? wr_q + 1'b1 : wr_q;
      rd_d = do_pop ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
   end
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign head = empty ? '0 : mem_q[rd_q];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: valid/ready front-end that drives a combinational ALU and buffers its results
// Ports: cmd_* command handshake in, alu_a/alu_b/alu_op registered ALU drive, alu_result in,
// res_* result FIFO head out, op_count completed-op counter (only when ALU_ISSUE_CNT_EN is defined).
module alu_issue_ctrl
   import alu_issue_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OPND_W-1:0] cmd_a,
   input  logic [OPND_W-1:0] cmd_b,
   input  logic [OP_W-1:0]   cmd_op,
   output logic [OPND_W-1:0] alu_a,
   output logic [OPND_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [RES_W-1:0]  alu_result,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [RES_W-1:0]  res_data,
   output logic [OP_W-1:0]   res_op
`ifdef ALU_ISSUE_CNT_EN
   ,
   output logic [7:0]        op_count
`endif
);
   localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [OPND_W-1:0] a_q, a_d, b_q, b_d;
   logic [OP_W-1:0] op_q, op_d;
   logic accept, push, fifo_empty;
   logic [AW:0] fifo_count;
   entry_t head;
`ifdef ALU_ISSUE_CNT_EN
   logic [7:0] opc_q, opc_d;
`endif
   always_comb begin
      cmd_ready = rst_n & (state_q == ST_IDLE) & (fifo_count != FULL_CNT);
      accept = cmd_valid & cmd_ready;
      push = (state_q == ST_SETTLE) & (cnt_q == '0);
      state_d = accept ? ST_SETTLE : (push ? ST_IDLE : state_q);
      cnt_d = accept ? CW'(SETTLE_CYCLES - 1) : ((state_q == ST_SETTLE) ? cnt_q - 1'b1 : cnt_q);
      a_d = accept ? cmd_a : a_q;
      b_d = accept ? cmd_b : b_q;
      op_d = accept ? cmd_op : op_q;
`ifdef ALU_ISSUE_CNT_EN
      opc_d = opc_q + {7'd0, push};
`endif
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q <= '0;
         a_q <= '0;
         b_q <= '0;
         op_q <= '0;
`ifdef ALU_ISSUE_CNT_EN
         opc_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         a_q <= a_d;
         b_q <= b_d;
         op_q <= op_d;
`ifdef ALU_ISSUE_CNT_EN
         opc_q <= opc_d;
`endif
      end
   end
   alu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ({alu_result, op_q}),
      .pop       (res_ready),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (head)
   );
   assign alu_a = a_q;
   assign alu_b = b_q;
   assign alu_op = op_q;
   assign res_valid = ~fifo_empty;
   assign res_data = head.result;
   assign res_op = head.op;
`ifdef ALU_ISSUE_CNT_EN
   assign op_count = opc_q;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with SETTLE_CYCLES=1 and SETTLE_CYCLES=3 instances
module tb_alu_issue_ctrl;
   logic clk = 0;
   logic rst_n, cmd_valid1, cmd_valid3, res_ready;
   logic [5:0] cmd_a, cmd_b;
   logic [1:0] cmd_op;
   logic rdy1, rv1, rdy3, rv3;
   logic [5:0] a1, b1, a3, b3;
   logic [1:0] op1, ro1, op3, ro3;
   logic [7:0] res1, rd1, res3, rd3;
`ifdef ALU_ISSUE_CNT_EN
   logic [7:0] cnt1, cnt3;
`endif
   int n_vec = 0;
   int n_err = 0;
   always #5 clk = ~clk;
   function automatic logic [7:0] alu(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op);
      logic [7:0] x, y;
      x = {{2{a[5]}}, a};
      y = {{2{b[5]}}, b};
      case (op)
         2'd0: return x + y;
         2'd1: return x - y;
         2'd2: return x & y;
         default: return x | y;
      endcase
   endfunction
   assign res1 = alu(a1, b1, op1);
   assign res3 = alu(a3, b3, op3);
   alu_issue_ctrl #(.SETTLE_CYCLES(1), .DEPTH(4)) u1 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(rdy1),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_result(res1),
      .res_valid(rv1), .res_ready(res_ready), .res_data(rd1), .res_op(ro1)
`ifdef ALU_ISSUE_CNT_EN
      , .op_count(cnt1)
`endif
   );
   alu_issue_ctrl #(.SETTLE_CYCLES(3), .DEPTH(4)) u3 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(rdy3),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(a3), .alu_b(b3), .alu_op(op3), .alu_result(res3),
      .res_valid(rv3), .res_ready(res_ready), .res_data(rd3), .res_op(ro3)
`ifdef ALU_ISSUE_CNT_EN
      , .op_count(cnt3)
`endif
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      rst_n = 0; cmd_valid1 = 0; cmd_valid3 = 0; res_ready = 0;
      cmd_a = '0; cmd_b = '0; cmd_op = '0;
      repeat (3) tick();
      n_vec++; if (rdy1 !== 1'b0) begin n_err++; $display("FAIL reset_cmd_ready got %b want 0", rdy1); end
      n_vec++; if ({a1, b1, op1} !== 14'd0) begin n_err++; $display("FAIL reset_alu_drive got %h want 0", {a1, b1, op1}); end
      n_vec++; if ({rv1, rd1, ro1} !== 11'd0) begin n_err++; $display("FAIL reset_res got %h want 0", {rv1, rd1, ro1}); end
`ifdef ALU_ISSUE_CNT_EN
      n_vec++; if (cnt1 !== 8'd0) begin n_err++; $display("FAIL reset_op_count got %0d want 0", cnt1); end
`endif
      rst_n = 1;
      #1;
      n_vec++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL release_cmd_ready got %b want 1", rdy1); end
      n_vec++; if (rv1 !== 1'b0) begin n_err++; $display("FAIL release_res_valid got %b want 0", rv1); end
   endtask
   task automatic test_single();
      cmd_a = 6'd10; cmd_b = 6'd13; cmd_op = 2'd0; cmd_valid1 = 1;
      tick();
      cmd_valid1 = 0;
      n_vec++; if ({a1, b1} !== {6'd10, 6'd13}) begin n_err++; $display("FAIL single_operands got %h want %h", {a1, b1}, {6'd10, 6'd13}); end
      n_vec++; if (rdy1 !== 1'b0) begin n_err++; $display("FAIL single_busy got %b want 0", rdy1); end
      n_vec++; if (rv1 !== 1'b0) begin n_err++; $display("FAIL single_early_valid got %b want 0", rv1); end
      tick();
      n_vec++; if (rv1 !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", rv1); end
      n_vec++; if (rd1 !== 8'd23) begin n_err++; $display("FAIL single_data got %0d want 23", rd1); end
      n_vec++; if (ro1 !== 2'd0) begin n_err++; $display("FAIL single_op got %0d want 0", ro1); end
      n_vec++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL single_ready_back got %b want 1", rdy1); end
      res_ready = 1;
      tick();
      res_ready = 0;
      n_vec++; if (rv1 !== 1'b0) begin n_err++; $display("FAIL single_popped got %b want 0", rv1); end
   endtask
   task automatic test_back_to_back();
      cmd_a = 6'd3; cmd_b = 6'd31; cmd_op = 2'd1; cmd_valid1 = 1;
      tick();
      cmd_a = 6'd5; cmd_b = 6'h3E; cmd_op = 2'd2;
      tick();
      n_vec++; if (a1 !== 6'd3) begin n_err++; $display("FAIL b2b_hold got %0d want 3", a1); end
      n_vec++; if (rd1 !== 8'hE4) begin n_err++; $display("FAIL b2b_neg_data got %h want e4", rd1); end
      tick();
      cmd_valid1 = 0;
      n_vec++; if (a1 !== 6'd5) begin n_err++; $display("FAIL b2b_second_accept got %0d want 5", a1); end
      tick();
      res_ready = 1;
      n_vec++; if ({rd1, ro1} !== {8'hE4, 2'd1}) begin n_err++; $display("FAIL b2b_pop0 got %h want %h", {rd1, ro1}, {8'hE4, 2'd1}); end
      tick();
      n_vec++; if ({rd1, ro1} !== {8'h04, 2'd2}) begin n_err++; $display("FAIL b2b_pop1 got %h want %h", {rd1, ro1}, {8'h04, 2'd2}); end
      tick();
      res_ready = 0;
      n_vec++; if (rv1 !== 1'b0) begin n_err++; $display("FAIL b2b_empty got %b want 0", rv1); end
   endtask
   task automatic test_fill();
      for (int i = 1; i <= 4; i++) begin
         cmd_a = 6'(i); cmd_b = 6'd1; cmd_op = 2'd0; cmd_valid1 = 1;
         tick();
         cmd_valid1 = 0;
         tick();
      end
      cmd_a = 6'd5; cmd_valid1 = 1;
      n_vec++; if (rdy1 !== 1'b0) begin n_err++; $display("FAIL fill_full_ready got %b want 0", rdy1); end
      tick();
      tick();
      n_vec++; if (a1 !== 6'd4) begin n_err++; $display("FAIL fill_not_accepted got %0d want 4", a1); end
      n_vec++; if (rd1 !== 8'd2) begin n_err++; $display("FAIL fill_head got %0d want 2", rd1); end
      res_ready = 1;
      tick();
      res_ready = 0;
      n_vec++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL fill_ready_after_pop got %b want 1", rdy1); end
      tick();
      cmd_valid1 = 0;
      n_vec++; if (a1 !== 6'd5) begin n_err++; $display("FAIL fill_fifth_accept got %0d want 5", a1); end
      tick();
      res_ready = 1;
      for (int e = 3; e <= 6; e++) begin
         n_vec++; if (rd1 !== 8'(e) || rv1 !== 1'b1) begin n_err++; $display("FAIL fill_order got %0d/%b want %0d/1", rd1, rv1, e); end
         tick();
      end
      res_ready = 0;
      n_vec++; if (rv1 !== 1'b0) begin n_err++; $display("FAIL fill_drained got %b want 0", rv1); end
   endtask
   task automatic test_simul_push_pop();
      for (int i = 1; i <= 4; i++) begin
         cmd_a = 6'(i); cmd_b = 6'd2; cmd_op = 2'd0; cmd_valid1 = 1;
         tick();
         cmd_valid1 = 0;
         res_ready = (i == 4);
         tick();
         res_ready = 0;
      end
      n_vec++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL simul_ready got %b want 1", rdy1); end
      res_ready = 1;
      for (int e = 4; e <= 6; e++) begin
         n_vec++; if (rd1 !== 8'(e) || rv1 !== 1'b1) begin n_err++; $display("FAIL simul_order got %0d/%b want %0d/1", rd1, rv1, e); end
         tick();
      end
      res_ready = 0;
      n_vec++; if (rv1 !== 1'b0) begin n_err++; $display("FAIL simul_count got %b want 0", rv1); end
`ifdef ALU_ISSUE_CNT_EN
      n_vec++; if (cnt1 !== 8'd12) begin n_err++; $display("FAIL op_count got %0d want 12", cnt1); end
`endif
   endtask
   task automatic test_settle3();
      cmd_a = 6'd7; cmd_b = 6'd1; cmd_op = 2'd3; cmd_valid3 = 1;
      tick();
      cmd_valid3 = 0;
      n_vec++; if ({rdy3, a3} !== {1'b0, 6'd7}) begin n_err++; $display("FAIL s3_accept got %h want %h", {rdy3, a3}, {1'b0, 6'd7}); end
      tick();
      tick();
      n_vec++; if (rv3 !== 1'b0) begin n_err++; $display("FAIL s3_early_valid got %b want 0", rv3); end
      tick();
      n_vec++; if ({rv3, rd3, ro3} !== {1'b1, 8'd7, 2'd3}) begin n_err++; $display("FAIL s3_push got %h want %h", {rv3, rd3, ro3}, {1'b1, 8'd7, 2'd3}); end
      res_ready = 1;
      tick();
      res_ready = 0;
   endtask
   task automatic test_reset_mid_settle();
      cmd_a = 6'h3B; cmd_b = 6'd2; cmd_op = 2'd0; cmd_valid3 = 1;
      tick();
      cmd_valid3 = 0;
      tick();
      rst_n = 0;
      #1;
      n_vec++; if (rdy3 !== 1'b0) begin n_err++; $display("FAIL rst_forces_ready got %b want 0", rdy3); end
      tick();
      rst_n = 1;
      repeat (4) tick();
      n_vec++; if ({rv3, a3} !== 7'd0) begin n_err++; $display("FAIL rst_abandon got %h want 0", {rv3, a3}); end
      n_vec++; if (rdy3 !== 1'b1) begin n_err++; $display("FAIL rst_idle_ready got %b want 1", rdy3); end
`ifdef ALU_ISSUE_CNT_EN
      n_vec++; if (cnt3 !== 8'd0) begin n_err++; $display("FAIL rst_op_count got %0d want 0", cnt3); end
`endif
   endtask
   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fill();
      test_simul_push_pop();
      test_settle3();
      test_reset_mid_settle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
